// File: rtl/tsu_pkg.sv
// Shared constants for the PTP time-stamp queue read side: register map, STAT bit
// positions, entry width and the drain FSM state encoding.
package tsu_pkg;

  localparam logic [1:0] TSU_REG_STAT    = 2'd0;
  localparam logic [1:0] TSU_REG_DATA_LO = 2'd1;
  localparam logic [1:0] TSU_REG_DATA_HI = 2'd2;
  localparam logic [1:0] TSU_REG_COUNT   = 2'd3;

  // Write-side STAT bits
  localparam int unsigned TSU_STAT_FLUSH     = 0;
  localparam int unsigned TSU_STAT_IRQ_EN_WR = 1;
  // Read-side STAT bits
  localparam int unsigned TSU_STAT_IRQ_EN    = 9;
  localparam int unsigned TSU_STAT_HOLD_VLD  = 16;
  localparam int unsigned TSU_STAT_UNDERRUN  = 17;

  localparam int unsigned TSU_ENTRY_W = 56;

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StWait,
    StFlush
  } tsu_rd_state_e;

endpackage

// File: rtl/tsu_queue_reader.sv
// Drains the PTP time-stamp queue one entry at a time into a holding register for the host.
// Optional interrupt output is built when TSU_RD_IRQ_EN is defined.
module tsu_queue_reader
  import tsu_pkg::*;
#(
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned QRST_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   q_rd_clk,
  input  logic                   rst,
  input  logic [1:0]             bus_addr,
  input  logic                   bus_rd,
  input  logic                   bus_wr,
  input  logic [31:0]            bus_wdata,
  output logic [31:0]            bus_rdata,
  output logic                   bus_rack,
  output logic                   q_rd_en,
  input  logic [7:0]             q_rd_stat,
  input  logic [TSU_ENTRY_W-1:0] q_rd_data,
  output logic                   q_rst
`ifdef TSU_RD_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam logic [7:0] LatLast   = 8'(RD_LATENCY - 1);
  localparam logic [7:0] QrstLen   = 8'(QRST_CYCLES);
  localparam logic [7:0] FlushLast = 8'(QRST_CYCLES + 1);

  tsu_rd_state_e          state_q, state_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic [7:0]             flush_cnt_q, flush_cnt_d;
  logic [TSU_ENTRY_W-1:0] hold_q, hold_d;
  logic                   hold_vld_q, hold_vld_d;
  logic                   underrun_q, underrun_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rack_q;
  logic                   q_rst_q, q_rst_d;
  logic                   irq_en;
  logic                   flush_req;
  logic                   unused_wdata;

  // STAT is the only writable register, so a write needs no address decode.
  assign flush_req    = bus_wr & bus_wdata[TSU_STAT_FLUSH];
  assign unused_wdata = ^bus_wdata[31:1];

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    underrun_d  = underrun_q;
    count_d     = count_q;
    rdata_d     = '0;
    q_rd_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!hold_vld_q && (q_rd_stat[3:0] != 4'd0)) state_d = StPop;
      end
      StPop: begin
        q_rd_en    = 1'b1;
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == LatLast) begin
          hold_d     = q_rd_data;
          hold_vld_d = 1'b1;
          state_d    = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StFlush: begin
        if (flush_cnt_q == FlushLast) state_d = StIdle;
        else flush_cnt_d = flush_cnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    // Reads always return the values in effect before any same-cycle write.
    if (bus_rd) begin
      unique case (bus_addr)
        TSU_REG_STAT: begin
          rdata_d                    = 32'(q_rd_stat);
          rdata_d[TSU_STAT_IRQ_EN]   = irq_en;
          rdata_d[TSU_STAT_HOLD_VLD] = hold_vld_q;
          rdata_d[TSU_STAT_UNDERRUN] = underrun_q;
          underrun_d                 = 1'b0;
        end
        TSU_REG_DATA_LO: begin
          if (hold_vld_q) rdata_d = hold_q[31:0];
          else underrun_d = 1'b1;
        end
        TSU_REG_DATA_HI: begin
          if (hold_vld_q) begin
            rdata_d = {8'd0, hold_q[TSU_ENTRY_W-1:32]};
            if (!flush_req) begin
              hold_vld_d = 1'b0;
              count_d    = count_q + 1'b1;
            end
          end else begin
            underrun_d = 1'b1;
          end
        end
        TSU_REG_COUNT: rdata_d = 32'(count_q);
        default: rdata_d = '0;
      endcase
    end

    // A flush overrides everything, including a latch in the last WAIT cycle.
    if (flush_req) begin
      state_d     = StFlush;
      flush_cnt_d = '0;
      hold_d      = hold_q;
      hold_vld_d  = 1'b0;
    end

    q_rst_d = (state_d == StFlush) && (flush_cnt_d < QrstLen);
  end

  always_ff @(posedge q_rd_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      underrun_q  <= 1'b0;
      count_q     <= '0;
      rdata_q     <= '0;
      rack_q      <= 1'b0;
      q_rst_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      underrun_q  <= underrun_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      rack_q      <= bus_rd;
      q_rst_q     <= q_rst_d;
    end
  end

`ifdef TSU_RD_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  // hold_vld_d drops on a consuming DATA_HI read or a flush, clearing irq one cycle later.
  always_ff @(posedge q_rd_clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (bus_wr) irq_en_q <= bus_wdata[TSU_STAT_IRQ_EN_WR];
      irq_q <= irq_en_q & hold_vld_q & hold_vld_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  assign bus_rdata = rdata_q;
  assign bus_rack  = rack_q;
  assign q_rst     = q_rst_q;

endmodule

// File: tb/tb_tsu_queue_reader.sv
// Self-checking bench for tsu_queue_reader: a behavioural queue plus a transaction-level
// expectation model (delivered order, count, underrun flag).
module tb_tsu_queue_reader;
  import tsu_pkg::*;

  logic        q_rd_clk = 1'b0;
  logic        rst;
  logic [1:0]  bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rack;
  logic        q_rd_en;
  logic [7:0]  q_rd_stat;
  logic [55:0] q_rd_data;
  logic        q_rst;
`ifdef TSU_RD_IRQ_EN
  logic        irq;
`endif

  tsu_queue_reader dut (
    .q_rd_clk  (q_rd_clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_rack  (bus_rack),
    .q_rd_en   (q_rd_en),
    .q_rd_stat (q_rd_stat),
    .q_rd_data (q_rd_data),
    .q_rst     (q_rst)
`ifdef TSU_RD_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 q_rd_clk = ~q_rd_clk;

  int errors = 0;
  int checks = 0;

  logic [55:0] fifo[$];   // physical queue contents
  logic [55:0] exp_q[$];  // entries the host is still expected to receive, in order
  int          m_count = 0;
  logic        m_underrun = 1'b0;
  logic        m_irq_en = 1'b0;
  int          pops = 0;
  int          bad_pops = 0;
  int          outstanding = 0;

  function automatic logic [31:0] stat_word(logic und, logic vld, logic ien, int depth);
    return (32'(und) << 17) | (32'(vld) << 16) | (32'(ien) << 9) | 32'(depth);
  endfunction

  // One clock cycle; the queue answers pops after one cycle and is cleared by q_rst.
  task automatic step();
    logic pop;
    pop = q_rd_en;
    if (pop) begin
      pops++;
      if (q_rd_stat[3:0] == 4'd0 || outstanding != 0) bad_pops++;
      outstanding = 1;
    end
    @(posedge q_rd_clk);
    #1;
    if (pop && fifo.size() > 0) q_rd_data = fifo.pop_front();
    if (q_rst) fifo.delete();
    q_rd_stat = {4'd0, 4'(fifo.size())};
  endtask

  task automatic push(input logic [55:0] v);
    fifo.push_back(v);
    exp_q.push_back(v);
    q_rd_stat = {4'd0, 4'(fifo.size())};
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic ack);
    bus_addr = a;
    bus_rd   = 1'b1;
    step();
    d      = bus_rdata;
    ack    = bus_rack;
    bus_rd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] w);
    bus_addr  = TSU_REG_STAT;
    bus_wdata = w;
    bus_wr    = 1'b1;
    step();
    bus_wr    = 1'b0;
    bus_wdata = '0;
  endtask

  // Polls STAT until hold_vld shows, bounded.
  task automatic wait_vld(output logic ok);
    logic [31:0] d;
    logic        a;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      bus_read(TSU_REG_STAT, d, a);
      if (d[16]) ok = 1'b1;
    end
    m_underrun = 1'b0;
  endtask

  task automatic get_entry(output logic ok, output logic [31:0] lo, output logic [31:0] hi);
    logic a;
    wait_vld(ok);
    bus_read(TSU_REG_DATA_LO, lo, a);
    bus_read(TSU_REG_DATA_HI, hi, a);
    if (ok) begin
      m_count = (m_count + 1) % 65536;
      outstanding = 0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    rst = 1'b1;
    bus_addr = '0; bus_rd = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
    q_rd_stat = '0; q_rd_data = '0;
    step(); step();
    checks++; if (bus_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus_rdata); end
    checks++; if (bus_rack !== 1'b0) begin errors++; $display("FAIL reset_rack: got %b want 0", bus_rack); end
    checks++; if (q_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", q_rd_en); end
    checks++; if (q_rst !== 1'b0) begin errors++; $display("FAIL reset_q_rst: got %b want 0", q_rst); end
`ifdef TSU_RD_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    rst = 1'b0;
    bus_read(TSU_REG_STAT, d, a);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_stat: got %h want 0", d); end
    bus_read(TSU_REG_COUNT, d, a);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_count: got %h want 0", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    logic        a;
    int          p0;
    p0 = pops;
    push(56'h00ABCDEF12345678);
    step();
    checks++; if (q_rd_en !== 1'b1) begin errors++; $display("FAIL single_pop: q_rd_en=%b want 1", q_rd_en); end
    step();
    checks++; if (q_rd_en !== 1'b0) begin errors++; $display("FAIL single_pop_end: q_rd_en=%b want 0", q_rd_en); end
    bus_read(TSU_REG_STAT, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_early_stat: got %h want 0", d); end
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL single_rack: got %b want 1", a); end
    bus_read(TSU_REG_STAT, d, a);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL single_vld_stat: got %h want 00010000", d); end
    bus_read(TSU_REG_DATA_LO, d, a);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL single_lo: got %h want 12345678", d); end
    bus_read(TSU_REG_DATA_HI, d, a);
    checks++; if (d !== 32'h00ABCDEF) begin errors++; $display("FAIL single_hi: got %h want 00abcdef", d); end
    void'(exp_q.pop_front());
    m_count++; outstanding = 0;
    bus_read(TSU_REG_COUNT, d, a);
    checks++; if (d !== 32'(m_count)) begin errors++; $display("FAIL single_count: got %0d want %0d", d, m_count); end
    checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL single_pops: got %0d want 1", pops - p0); end
  endtask

  task automatic test_random_drain();
    logic [31:0] d, lo, hi;
    logic [55:0] v;
    logic        a, ok;
    int          k, p0;
    for (int r = 0; r < 4; r++) begin
      p0 = pops;
      k = (r == 0) ? 3 : int'($urandom_range(1, 5));
      for (int i = 0; i < k; i++) begin
        v = {4'd0, 20'($urandom()), $urandom()};
        push(v);
      end
      for (int i = 0; i < k; i++) begin
        repeat ($urandom_range(0, 3)) step();
        get_entry(ok, lo, hi);
        v = exp_q.pop_front();
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_timeout: round %0d entry %0d", r, i); end
        checks++; if (lo !== v[31:0]) begin errors++; $display("FAIL drain_lo: got %h want %h", lo, v[31:0]); end
        checks++; if (hi !== {8'd0, v[55:32]}) begin errors++; $display("FAIL drain_hi: got %h want %h", hi, {8'd0, v[55:32]}); end
      end
      repeat (8) step();
      checks++; if (pops - p0 !== k) begin errors++; $display("FAIL drain_pops: got %0d want %0d", pops - p0, k); end
      bus_read(TSU_REG_STAT, d, a);
      checks++; if (d !== stat_word(1'b0, 1'b0, m_irq_en, 0)) begin errors++; $display("FAIL drain_stat: got %h want %h", d, stat_word(1'b0, 1'b0, m_irq_en, 0)); end
      bus_read(TSU_REG_COUNT, d, a);
      checks++; if (d !== 32'(m_count)) begin errors++; $display("FAIL drain_count: got %0d want %0d", d, m_count); end
    end
  endtask

  task automatic test_underrun();
    logic [31:0] d;
    logic        a;
    bus_read(TSU_REG_DATA_HI, d, a);
    m_underrun = 1'b1;
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL underrun_data: got %h want 0", d); end
    bus_read(TSU_REG_COUNT, d, a);
    checks++; if (d !== 32'(m_count)) begin errors++; $display("FAIL underrun_count: got %0d want %0d", d, m_count); end
    bus_read(TSU_REG_STAT, d, a);
    checks++; if (d !== stat_word(m_underrun, 1'b0, m_irq_en, 0)) begin errors++; $display("FAIL underrun_set: got %h want %h", d, stat_word(m_underrun, 1'b0, m_irq_en, 0)); end
    m_underrun = 1'b0;
    bus_read(TSU_REG_STAT, d, a);
    checks++; if (d !== stat_word(m_underrun, 1'b0, m_irq_en, 0)) begin errors++; $display("FAIL underrun_clear: got %h want %h", d, stat_word(m_underrun, 1'b0, m_irq_en, 0)); end
  endtask

  task automatic test_flush_wait();
    logic [31:0] d, lo, hi;
    logic [55:0] v;
    logic        a, ok;
    push({4'd0, 52'hBAD0_0000_0BAD});
    push({4'd0, 52'hBAD0_0000_0BAE});
    step(); step();   // pop, then in WAIT
    bus_write(32'h1);
    exp_q.delete();
    outstanding = 0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (q_rst !== (i < 4)) begin errors++; $display("FAIL flush_q_rst[%0d]: got %b want %b", i, q_rst, i < 4); end
      checks++; if (q_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en[%0d]: got %b want 0", i, q_rd_en); end
      if (i == 4) push({4'd0, 52'h5_1234_5678_9ABC});
      step();
    end
    bus_read(TSU_REG_STAT, d, a);
    checks++; if (d[16] !== 1'b0) begin errors++; $display("FAIL flush_vld: got %b want 0", d[16]); end
    get_entry(ok, lo, hi);
    v = exp_q.pop_front();
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flush_next_timeout: no entry after flush"); end
    checks++; if ({hi[23:0], lo} !== v) begin errors++; $display("FAIL flush_next_entry: got %h want %h", {hi[23:0], lo}, v); end
    bus_read(TSU_REG_COUNT, d, a);
    checks++; if (d !== 32'(m_count)) begin errors++; $display("FAIL flush_count: got %0d want %0d", d, m_count); end
  endtask

  task automatic test_flush_and_hi();
    logic [31:0] d;
    logic [55:0] v;
    logic        a, ok;
    v = {4'd0, 20'($urandom()), $urandom()};
    push(v);
    wait_vld(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flush_hi_timeout: entry never held"); end
    bus_addr = TSU_REG_DATA_HI; bus_rd = 1'b1; bus_wr = 1'b1; bus_wdata = 32'h1;
    step();
    bus_rd = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
    exp_q.delete();
    outstanding = 0;
    checks++; if (bus_rdata !== {8'd0, v[55:32]}) begin errors++; $display("FAIL flush_hi_rdata: got %h want %h", bus_rdata, {8'd0, v[55:32]}); end
    checks++; if (q_rst !== 1'b1) begin errors++; $display("FAIL flush_hi_q_rst: got %b want 1", q_rst); end
    repeat (6) step();
    bus_read(TSU_REG_COUNT, d, a);
    checks++; if (d !== 32'(m_count)) begin errors++; $display("FAIL flush_hi_count: got %0d want %0d", d, m_count); end
    bus_read(TSU_REG_STAT, d, a);
    checks++; if (d !== stat_word(1'b0, 1'b0, m_irq_en, 0)) begin errors++; $display("FAIL flush_hi_stat: got %h want %h", d, stat_word(1'b0, 1'b0, m_irq_en, 0)); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic        a;
    bus_write(32'h2);
`ifdef TSU_RD_IRQ_EN
    m_irq_en = 1'b1;
`endif
    bus_read(TSU_REG_STAT, d, a);
    checks++; if (d !== stat_word(1'b0, 1'b0, m_irq_en, 0)) begin errors++; $display("FAIL irq_en_stat: got %h want %h", d, stat_word(1'b0, 1'b0, m_irq_en, 0)); end
`ifdef TSU_RD_IRQ_EN
    push(56'h0011_2233_4455_66);
    step(); step(); step();   // hold_vld rises now
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq); end
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq); end
    bus_read(TSU_REG_DATA_HI, d, a);
    void'(exp_q.pop_front());
    m_count++; outstanding = 0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irq); end
    bus_write(32'h0);
    m_irq_en = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        a;
    bus_write(32'h1);
    checks++; if (q_rst !== 1'b1) begin errors++; $display("FAIL rstmid_q_rst_pre: got %b want 1", q_rst); end
    rst = 1'b1;
    step();
    checks++; if (q_rst !== 1'b0) begin errors++; $display("FAIL rstmid_q_rst: got %b want 0", q_rst); end
    rst = 1'b0;
    m_count = 0; m_underrun = 1'b0; m_irq_en = 1'b0; outstanding = 0;
    exp_q.delete(); fifo.delete();
    q_rd_stat = '0;
    bus_read(TSU_REG_COUNT, d, a);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", d); end
  endtask

  task automatic test_count_wrap();
    logic [31:0] d, lo, hi;
    logic        a, ok;
    force dut.count_q = 16'hFFFF;
    step();
    release dut.count_q;
    m_count = 65535;
    bus_read(TSU_REG_COUNT, d, a);
    checks++; if (d !== 32'(m_count)) begin errors++; $display("FAIL wrap_pre: got %h want %h", d, m_count); end
    push({4'd0, 52'hF_EDCB_A987_6543});
    get_entry(ok, lo, hi);
    void'(exp_q.pop_front());
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_timeout: entry never held"); end
    bus_read(TSU_REG_COUNT, d, a);
    checks++; if (d !== 32'(m_count)) begin errors++; $display("FAIL wrap_count: got %h want %h", d, m_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_drain();
    test_underrun();
    test_flush_wait();
    test_flush_and_hi();
    test_irq();
    test_reset_mid();
    test_count_wrap();
    checks++; if (bad_pops !== 0) begin errors++; $display("FAIL pop_rule: %0d illegal pops, want 0", bad_pops); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
